full_adder: RTL and testbench

Parameterizable binary adder: adds two WIDTH-bit operands plus a carry-in and produces a WIDTH-bit sum and a carry-out. The default configuration (WIDTH=1, OUT_REG=0) is the classic purely combinational 1-bit full adder. Larger widths are built as a ripple chain of 1-bit cells. An optional output register stage lets the block sit directly in a clocked datapath.

---
 rtl/full_adder_pkg.sv | 9 +
 rtl/full_adder_cell.sv | 16 +
 rtl/full_adder.sv | 66 ++++++
 tb/tb_full_adder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder block: width limit and output-stage selector.
package full_adder_pkg;

  localparam int unsigned FA_MAX_WIDTH = 64;

  localparam int unsigned FA_COMB = 0;
  localparam int unsigned FA_REG  = 1;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder cell; chained by full_adder to form a ripple adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from full_adder_cell, with an optional
// output register stage (asynchronous active-low reset).
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned OUT_REG = FA_COMB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "full_adder: WIDTH must be in 1..FA_MAX_WIDTH");
  end

  if (OUT_REG != FA_COMB && OUT_REG != FA_REG) begin : g_bad_out_reg
    $fatal(1, "full_adder: OUT_REG must be FA_COMB or FA_REG");
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;

  assign c[0] = carryIn;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum_d[i]),
      .cout (c[i+1])
    );
  end

  if (OUT_REG == FA_REG) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= c[WIDTH];
      end
    end

    assign sum      = sum_q;
    assign carryOut = carry_q;
  end else begin : g_comb
    // Clock and reset are intentionally unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;

    assign sum      = sum_d;
    assign carryOut = c[WIDTH];
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: combinational and registered configurations.
module tb_full_adder;
  import full_adder_pkg::*;

  typedef struct packed {
    logic a;
    logic b;
    logic ci;
    logic s;
    logic co;
  } vec1_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec8_t;

  int unsigned tests;
  int unsigned failed;

  logic clk;

  // WIDTH=1 combinational
  logic a1, b1, ci1, s1, co1;
  // WIDTH=8 combinational
  logic [7:0] a8, b8, s8;
  logic       ci8, co8;
  // WIDTH=4 registered
  logic       rst4_n;
  logic [3:0] a4, b4, s4;
  logic       ci4, co4;
  // WIDTH=1 registered
  logic       rst1_n;
  logic       a1r, b1r, ci1r, s1r, co1r;

  full_adder #(.WIDTH(1), .OUT_REG(FA_COMB)) u_w1c (
    .clk(clk), .rst_n(1'b1), .a(a1), .b(b1), .carryIn(ci1), .sum(s1), .carryOut(co1)
  );

  full_adder #(.WIDTH(8), .OUT_REG(FA_COMB)) u_w8c (
    .clk(clk), .rst_n(1'b1), .a(a8), .b(b8), .carryIn(ci8), .sum(s8), .carryOut(co8)
  );

  full_adder #(.WIDTH(4), .OUT_REG(FA_REG)) u_w4r (
    .clk(clk), .rst_n(rst4_n), .a(a4), .b(b4), .carryIn(ci4), .sum(s4), .carryOut(co4)
  );

  full_adder #(.WIDTH(1), .OUT_REG(FA_REG)) u_w1r (
    .clk(clk), .rst_n(rst1_n), .a(a1r), .b(b1r), .carryIn(ci1r), .sum(s1r), .carryOut(co1r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  vec1_t tt[9];
  vec8_t t8[5];

  initial begin
    tt[0] = '{a:0, b:0, ci:0, s:0, co:0};
    tt[1] = '{a:0, b:0, ci:1, s:1, co:0};
    tt[2] = '{a:0, b:1, ci:0, s:1, co:0};
    tt[3] = '{a:0, b:1, ci:1, s:0, co:1};
    tt[4] = '{a:1, b:0, ci:0, s:1, co:0};
    tt[5] = '{a:1, b:0, ci:1, s:0, co:1};
    tt[6] = '{a:1, b:1, ci:0, s:0, co:1};
    tt[7] = '{a:1, b:1, ci:1, s:1, co:1};
    tt[8] = '{a:0, b:0, ci:0, s:0, co:0};

    t8[0] = '{a:8'hFF, b:8'h00, ci:1'b1, s:8'h00, co:1'b1};
    t8[1] = '{a:8'h80, b:8'h80, ci:1'b0, s:8'h00, co:1'b1};
    t8[2] = '{a:8'h0F, b:8'h01, ci:1'b0, s:8'h10, co:1'b0};
    t8[3] = '{a:8'hFF, b:8'hFF, ci:1'b1, s:8'hFF, co:1'b1};
    t8[4] = '{a:8'h55, b:8'hAA, ci:1'b0, s:8'hFF, co:1'b0};

    tests = 0;
    failed = 0;
    {a1, b1, ci1} = '0;
    {a8, b8, ci8} = '0;
    {a4, b4, ci4} = '0;
    {a1r, b1r, ci1r} = '0;
    rst4_n = 1'b0;
    rst1_n = 1'b0;

    // Registered outputs during reset
    #1;
    check("w4_reset", {59'd0, co4, s4}, 64'd0);
    check("w1r_reset", {62'd0, co1r, s1r}, 64'd0);

    // WIDTH=1 exhaustive truth table
    for (int i = 0; i < 9; i++) begin
      a1 = tt[i].a; b1 = tt[i].b; ci1 = tt[i].ci;
      #111;
      check($sformatf("w1_tt[%0d]", i), {62'd0, co1, s1}, {62'd0, tt[i].co, tt[i].s});
    end

    // WIDTH=8 directed carry-ripple vectors
    for (int i = 0; i < 5; i++) begin
      a8 = t8[i].a; b8 = t8[i].b; ci8 = t8[i].ci;
      #1;
      check($sformatf("w8_dir[%0d]", i), {55'd0, co8, s8}, {55'd0, t8[i].co, t8[i].s});
    end

    // WIDTH=8 random arithmetic identity
    for (int i = 0; i < 10000; i++) begin
      logic [8:0] exp9;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      ci8 = 1'($urandom);
      exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, ci8};
      #1;
      check("w8_rand", {55'd0, co8, s8}, {55'd0, exp9});
    end

    // WIDTH=4 registered: latency and hold between edges
    @(negedge clk);
    rst4_n = 1'b1;
    rst1_n = 1'b1;
    a4 = 4'h9; b4 = 4'h8; ci4 = 1'b1;
    #2;
    check("w4_pre_edge", {59'd0, co4, s4}, 64'd0);
    @(posedge clk); #1;
    check("w4_latency", {59'd0, co4, s4}, {59'd0, 1'b1, 4'h2});
    #2;
    a4 = 4'h1; b4 = 4'h1; ci4 = 1'b0;
    #2;
    check("w4_hold", {59'd0, co4, s4}, {59'd0, 1'b1, 4'h2});
    @(posedge clk); #1;
    check("w4_next", {59'd0, co4, s4}, {59'd0, 1'b0, 4'h2});

    // WIDTH=4 registered: asynchronous reset mid-cycle
    @(negedge clk); #2;
    rst4_n = 1'b0;
    #1;
    check("w4_async_rst", {59'd0, co4, s4}, 64'd0);
    a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
    @(posedge clk); #1;
    check("w4_rst_held", {59'd0, co4, s4}, 64'd0);
    @(negedge clk);
    rst4_n = 1'b1;
    #1;
    check("w4_rst_release", {59'd0, co4, s4}, 64'd0);
    @(posedge clk); #1;
    check("w4_first_load", {59'd0, co4, s4}, {59'd0, 1'b1, 4'hF});

    // WIDTH=1 registered streaming through all combinations
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0)
        check("w1r_stream_prev[0]", {62'd0, co1r, s1r}, 64'd0);
      else
        check($sformatf("w1r_stream_prev[%0d]", i), {62'd0, co1r, s1r},
              {62'd0, tt[i-1].co, tt[i-1].s});
      a1r = tt[i].a; b1r = tt[i].b; ci1r = tt[i].ci;
      @(posedge clk); #1;
      check($sformatf("w1r_stream[%0d]", i), {62'd0, co1r, s1r}, {62'd0, tt[i].co, tt[i].s});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
